// File: rtl/aes_key_schedule_seq.sv
// aes_key_schedule_seq
//   Iterative AES-128 key expansion. A single round-key datapath is reused
//   over time: the cipher key is loaded on start and each accepted round key
//   is replaced by the next one, giving round keys 0..NR in order.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   start      in   1    load key_in and begin expansion (only when busy=0)
//   key_in     in   128  cipher key, FIPS-197 byte order (MSB = byte 0)
//   rk_ready   in   1    consumer accepts the current round key
//   rk_valid   out  1    round_key/rk_index are valid
//   round_key  out  128  round key w[4i..4i+3], w[4i] in bits 127:96
//   rk_index   out  4    round number i of round_key, 0..NR
//   busy       out  1    expansion in progress (FSM in RUN)
//   done       out  1    one-cycle pulse after the round NR key is accepted
//
// Handshake: a round key transfers on a rising edge where rk_valid and
// rk_ready are both 1. While rk_valid=1 and rk_ready=0, round_key, rk_index
// and rk_valid hold steady; rk_valid never drops without a transfer (except
// on reset). rk_ready may be asserted independently of rk_valid.
//
// busy is the FSM state itself (IDLE=0, RUN=1), so it doubles as the state
// observation point.

module aes_key_schedule_seq #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [127:0]       key_in,
  input  logic               rk_ready,
  output logic               rk_valid,
  output logic [127:0]       round_key,
  output logic [IDX_W-1:0]   rk_index,
  output logic               busy,
  output logic               done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);

  // AES forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    logic [10:0] base;
    base = 11'd2047 - {b, 3'b000};
    return SBOX_TBL[base -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]),
            sub_byte(w[15:8]),  sub_byte(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state;
  state_e             state_n;
  logic [127:0]       round_key_n;
  logic [IDX_W-1:0]   rk_index_n;
  logic [7:0]         rcon;
  logic [7:0]         rcon_n;
  logic               done_n;

  logic [31:0]        w0;
  logic [31:0]        w1;
  logic [31:0]        w2;
  logic [31:0]        w3;
  logic [31:0]        t;
  logic [31:0]        n0;
  logic [31:0]        n1;
  logic [31:0]        n2;
  logic [31:0]        n3;

  // Next round key, one combinational step from the current registered key.
  assign w0 = round_key[127:96];
  assign w1 = round_key[95:64];
  assign w2 = round_key[63:32];
  assign w3 = round_key[31:0];
  assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rk_valid = (state == RUN);
  assign busy     = (state == RUN);

  always_comb begin
    state_n     = state;
    round_key_n = round_key;
    rk_index_n  = rk_index;
    rcon_n      = rcon;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        // key_in is only sampled here, so a start while RUN cannot disturb
        // an expansion in progress.
        if (start) begin
          state_n     = RUN;
          round_key_n = key_in;
          rk_index_n  = '0;
          rcon_n      = 8'h01;
        end
      end
      RUN: begin
        if (rk_ready) begin
          if (rk_index == LAST_IDX) begin
            // Last key consumed; round_key/rk_index keep their final values
            // but are no longer qualified by rk_valid.
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            round_key_n = {n0, n1, n2, n3};
            rk_index_n  = rk_index + IDX_W'(1);
            rcon_n      = xtime(rcon);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      round_key <= '0;
      rk_index  <= '0;
      rcon      <= 8'h01;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      round_key <= round_key_n;
      rk_index  <= rk_index_n;
      rcon      <= rcon_n;
      done      <= done_n;
    end
  end

endmodule
